pipeline_hazard_ctrl: RTL and testbench

Central hazard controller for the 5-stage 8-bit pipeline. It generates the stall, flush and forwarding controls for the IF/ID and ID/EX registers and the EX operand muxes. It also sequences the multi-cycle RET drain and interrupt entry (drain, push PC, push flags, load vector) with an internal FSM and bubble counter. It is the sole driver of `flush_E` into the ID/EX register.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_seq_fsm.sv | 130 +++++++++++++
 rtl/pipeline_hazard_ctrl.sv | 88 ++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
`default_nettype none

package hazard_pkg;

  typedef enum logic [2:0] {
    ST_IDLE           = 3'd0,
    ST_RET_WAIT       = 3'd1,
    ST_INT_DRAIN      = 3'd2,
    ST_INT_PUSH_PC    = 3'd3,
    ST_INT_PUSH_FLAGS = 3'd4,
    ST_INT_VECTOR     = 3'd5
  } hz_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/hazard_seq_fsm.sv
// RET drain / interrupt entry sequencer: state register, bubble counter and
// per-state stall, flush and strobe decode.
`default_nettype none

module hazard_seq_fsm
  import hazard_pkg::*;
#(
  parameter int RET_BUBBLES  = 2,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic branch_taken,
  input  logic is_ret,
  input  logic intr,
  input  logic load_use,
  output logic stall_f,
  output logic stall_d,
  output logic flush_d,
  output logic flush_e,
  output logic ret_pc_load,
  output logic int_push_pc,
  output logic int_push_flags,
  output logic int_vec_load,
  output logic int_ack,
  output logic busy
);

  localparam logic [2:0] RET_LOAD   = 3'(RET_BUBBLES - 1);
  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  hz_state_t  state, state_nx;
  logic [2:0] cnt, cnt_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    stall_f        = 1'b0;
    stall_d        = 1'b0;
    flush_d        = 1'b0;
    flush_e        = 1'b0;
    ret_pc_load    = 1'b0;
    int_push_pc    = 1'b0;
    int_push_flags = 1'b0;
    int_vec_load   = 1'b0;
    int_ack        = 1'b0;
    busy           = 1'b0;
    // Reset is level-sensitive here so every output drops the moment it asserts.
    if (reset) begin
      busy = (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (branch_taken) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
          end else if (is_ret) begin
            stall_f  = 1'b1;
            flush_d  = 1'b1;
            flush_e  = 1'b1;
            cnt_nx   = RET_LOAD;
            state_nx = ST_RET_WAIT;
          end else if (intr) begin
            stall_f  = 1'b1;
            flush_d  = 1'b1;
            cnt_nx   = DRAIN_LOAD;
            state_nx = ST_INT_DRAIN;
          end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end
        end
        ST_RET_WAIT: begin
          flush_d = 1'b1;
          flush_e = 1'b1;
          if (cnt == 3'd0) begin
            ret_pc_load = 1'b1;
            state_nx    = ST_IDLE;
          end else begin
            stall_f = 1'b1;
            cnt_nx  = cnt - 3'd1;
          end
        end
        ST_INT_DRAIN: begin
          stall_f = 1'b1;
          flush_d = 1'b1;
          flush_e = 1'b1;
          if (cnt == 3'd0) state_nx = ST_INT_PUSH_PC;
          else             cnt_nx   = cnt - 3'd1;
        end
        ST_INT_PUSH_PC: begin
          stall_f     = 1'b1;
          flush_d     = 1'b1;
          flush_e     = 1'b1;
          int_push_pc = 1'b1;
          state_nx    = ST_INT_PUSH_FLAGS;
        end
        ST_INT_PUSH_FLAGS: begin
          stall_f        = 1'b1;
          flush_d        = 1'b1;
          flush_e        = 1'b1;
          int_push_flags = 1'b1;
          state_nx       = ST_INT_VECTOR;
        end
        ST_INT_VECTOR: begin
          // PC is released so the vector address is fetched this cycle.
          flush_d      = 1'b1;
          flush_e      = 1'b1;
          int_vec_load = 1'b1;
          int_ack      = 1'b1;
          state_nx     = ST_IDLE;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller top: EX operand forwarding, load-use detection and the
// RET / interrupt sequencer.
`default_nettype none

module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RET_BUBBLES  = 2,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] ra_d,
  input  logic [1:0] rb_d,
  input  logic       uses_ra_d,
  input  logic       uses_rb_d,
  input  logic [1:0] ra_e,
  input  logic [1:0] rb_e,
  input  logic [1:0] dst_e,
  input  logic       wr_en_regf_e,
  input  logic       rd_en_e,
  input  logic [1:0] dst_m,
  input  logic       wr_en_regf_m,
  input  logic [1:0] dst_w,
  input  logic       wr_en_regf_w,
  input  logic       branch_taken_e,
  input  logic       is_ret_e,
  input  logic       intr,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d,
  output logic       flush_e,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       ret_pc_load,
  output logic       int_push_pc,
  output logic       int_push_flags,
  output logic       int_vec_load,
  output logic       int_ack,
  output logic       busy
);

  logic load_use;

  function automatic logic [1:0] fwd_pick(input logic [1:0] src);
    if (wr_en_regf_m && (dst_m == src))      return FWD_MEM;
    else if (wr_en_regf_w && (dst_w == src)) return FWD_WB;
    else                                     return FWD_RF;
  endfunction

  always_comb begin
    fwd_a_sel = FWD_RF;
    fwd_b_sel = FWD_RF;
    if (reset) begin
      fwd_a_sel = fwd_pick(ra_e);
      fwd_b_sel = fwd_pick(rb_e);
    end
  end

  assign load_use = rd_en_e && wr_en_regf_e &&
                    ((uses_ra_d && (dst_e == ra_d)) ||
                     (uses_rb_d && (dst_e == rb_d)));

  hazard_seq_fsm #(
    .RET_BUBBLES  (RET_BUBBLES),
    .DRAIN_CYCLES (DRAIN_CYCLES)
  ) u_seq (
    .clk            (clk),
    .reset          (reset),
    .branch_taken   (branch_taken_e),
    .is_ret         (is_ret_e),
    .intr           (intr),
    .load_use       (load_use),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .flush_d        (flush_d),
    .flush_e        (flush_e),
    .ret_pc_load    (ret_pc_load),
    .int_push_pc    (int_push_pc),
    .int_push_flags (int_push_flags),
    .int_vec_load   (int_vec_load),
    .int_ack        (int_ack),
    .busy           (busy)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized bench for pipeline_hazard_ctrl against a timeline-based model.
`default_nettype none

module tb_pipeline_hazard_ctrl;

  localparam int RB = 2;
  localparam int DC = 3;

  // Control bit order: stall_f stall_d flush_d flush_e ret_pc_load push_pc push_flags vec_load ack
  localparam logic [8:0] C_BRANCH = 9'b0_0_1_1_0_0_0_0_0;
  localparam logic [8:0] C_HOLD   = 9'b1_0_1_1_0_0_0_0_0;
  localparam logic [8:0] C_INTR   = 9'b1_0_1_0_0_0_0_0_0;
  localparam logic [8:0] C_LU     = 9'b1_1_0_1_0_0_0_0_0;
  localparam logic [8:0] C_RETEND = 9'b0_0_1_1_1_0_0_0_0;
  localparam logic [8:0] C_PP     = 9'b1_0_1_1_0_1_0_0_0;
  localparam logic [8:0] C_PF     = 9'b1_0_1_1_0_0_1_0_0;
  localparam logic [8:0] C_VEC    = 9'b0_0_1_1_0_0_0_1_1;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] ra_d, rb_d, ra_e, rb_e, dst_e, dst_m, dst_w;
  logic       uses_ra_d, uses_rb_d, wr_en_regf_e, rd_en_e, wr_en_regf_m, wr_en_regf_w;
  logic       branch_taken_e, is_ret_e, intr;
  logic       stall_f, stall_d, flush_d, flush_e, ret_pc_load;
  logic       int_push_pc, int_push_flags, int_vec_load, int_ack, busy;
  logic [1:0] fwd_a_sel, fwd_b_sel;

  int checks = 0;
  int failures = 0;
  logic [8:0] plan[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.RET_BUBBLES(RB), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .reset(reset),
    .ra_d(ra_d), .rb_d(rb_d), .uses_ra_d(uses_ra_d), .uses_rb_d(uses_rb_d),
    .ra_e(ra_e), .rb_e(rb_e), .dst_e(dst_e), .wr_en_regf_e(wr_en_regf_e), .rd_en_e(rd_en_e),
    .dst_m(dst_m), .wr_en_regf_m(wr_en_regf_m), .dst_w(dst_w), .wr_en_regf_w(wr_en_regf_w),
    .branch_taken_e(branch_taken_e), .is_ret_e(is_ret_e), .intr(intr),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .ret_pc_load(ret_pc_load),
    .int_push_pc(int_push_pc), .int_push_flags(int_push_flags),
    .int_vec_load(int_vec_load), .int_ack(int_ack), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [1:0] src);
    if (wr_en_regf_m && dst_m == src) return 2'b01;
    if (wr_en_regf_w && dst_w == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [8:0] idle_ctl();
    logic lu;
    lu = rd_en_e && wr_en_regf_e &&
         ((uses_ra_d && dst_e == ra_d) || (uses_rb_d && dst_e == rb_d));
    if (branch_taken_e) return C_BRANCH;
    if (is_ret_e)       return C_HOLD;
    if (intr)           return C_INTR;
    if (lu)             return C_LU;
    return 9'd0;
  endfunction

  function automatic logic [13:0] observed();
    return {stall_f, stall_d, flush_d, flush_e, fwd_a_sel, fwd_b_sel,
            ret_pc_load, int_push_pc, int_push_flags, int_vec_load, int_ack, busy};
  endfunction

  function automatic logic [13:0] expected();
    logic [8:0] ctl;
    logic       bsy;
    if (!reset) return 14'd0;
    bsy = (plan.size() != 0);
    ctl = bsy ? plan[0] : idle_ctl();
    return {ctl[8:5], ref_fwd(ra_e), ref_fwd(rb_e), ctl[4:0], bsy};
  endfunction

  // Check the current cycle, then advance the model across the rising edge.
  task automatic step(input string tag);
    #1;
    check(tag, 32'(observed()), 32'(expected()));
    @(posedge clk);
    if (!reset) begin
      plan.delete();
    end else if (plan.size() != 0) begin
      void'(plan.pop_front());
    end else if (!branch_taken_e && is_ret_e) begin
      for (int i = 0; i < RB - 1; i++) plan.push_back(C_HOLD);
      plan.push_back(C_RETEND);
    end else if (!branch_taken_e && intr) begin
      for (int i = 0; i < DC; i++) plan.push_back(C_HOLD);
      plan.push_back(C_PP);
      plan.push_back(C_PF);
      plan.push_back(C_VEC);
    end
    #1;
  endtask

  task automatic clear_inputs();
    {ra_d, rb_d, ra_e, rb_e, dst_e, dst_m, dst_w} = '0;
    {uses_ra_d, uses_rb_d, wr_en_regf_e, rd_en_e, wr_en_regf_m, wr_en_regf_w} = '0;
    {branch_taken_e, is_ret_e, intr} = '0;
  endtask

  task automatic random_inputs();
    ra_d = 2'($urandom); rb_d = 2'($urandom);
    ra_e = 2'($urandom); rb_e = 2'($urandom);
    dst_e = 2'($urandom); dst_m = 2'($urandom); dst_w = 2'($urandom);
    uses_ra_d = 1'($urandom); uses_rb_d = 1'($urandom);
    wr_en_regf_e = 1'($urandom); wr_en_regf_m = 1'($urandom); wr_en_regf_w = 1'($urandom);
    rd_en_e = ($urandom_range(0, 2) == 0);
    branch_taken_e = ($urandom_range(0, 7) == 0);
    is_ret_e = ($urandom_range(0, 9) == 0);
    intr = ($urandom_range(0, 11) == 0);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    ra_e = 2'd2; dst_m = 2'd2; wr_en_regf_m = 1'b1; intr = 1'b1;
    @(posedge clk); #1;
    step("reset_outputs_zero");
    check("reset_fwd_a", 32'(fwd_a_sel), 32'd0);
    reset = 1'b1;
    clear_inputs();

    // Forwarding priority
    ra_e = 2'd2; dst_m = 2'd2; wr_en_regf_m = 1'b1; dst_w = 2'd2; wr_en_regf_w = 1'b1;
    #1 check("fwd_mem_wins", 32'(fwd_a_sel), 32'b01);
    step("fwd_mem");
    wr_en_regf_m = 1'b0;
    #1 check("fwd_wb", 32'(fwd_a_sel), 32'b10);
    step("fwd_wb_model");
    clear_inputs();

    // Load-use
    rd_en_e = 1'b1; wr_en_regf_e = 1'b1; dst_e = 2'd1; rb_d = 2'd1; uses_rb_d = 1'b1;
    #1 check("load_use_stall", 32'({stall_f, stall_d, flush_e}), 32'b111);
    step("load_use");
    uses_rb_d = 1'b0;
    #1 check("load_use_unused", 32'({stall_f, stall_d, flush_e}), 32'b000);
    step("load_use_none");

    // Branch beats load-use
    uses_rb_d = 1'b1; branch_taken_e = 1'b1;
    #1 check("branch_vs_lu", 32'({stall_f, stall_d, flush_d, flush_e}), 32'b0011);
    step("branch_lu");
    clear_inputs();

    // RET with an interrupt arriving mid-drain
    is_ret_e = 1'b1;
    #1 check("ret_c0_stall", 32'(stall_f), 32'd1);
    step("ret_c0");
    is_ret_e = 1'b0; intr = 1'b1;
    #1 check("ret_c1_stall_busy", 32'({stall_f, busy, int_push_pc}), 32'b110);
    step("ret_c1");
    #1 check("ret_c2_load", 32'({ret_pc_load, stall_f}), 32'b10);
    step("ret_c2");
    #1 check("intr_taken_after_ret", 32'({busy, stall_f, flush_d, flush_e}), 32'b0110);
    step("int_c0");
    for (int k = 1; k <= 7; k++) begin
      if (k == 7) intr = 1'b0;
      #1;
      check($sformatf("int_strobes_%0d", k),
            32'({int_push_pc, int_push_flags, int_vec_load, int_ack, busy}),
            32'({k == 4, k == 5, k == 6, k == 6, k != 7}));
      step("int_seq");
    end
    clear_inputs();

    // Reset during INT_PUSH_FLAGS
    intr = 1'b1;
    for (int k = 0; k < 5; k++) step("int_pre_reset");
    intr = 1'b0;
    #1 check("at_push_flags", 32'(int_push_flags), 32'd1);
    ra_e = 2'd3; dst_w = 2'd3; wr_en_regf_w = 1'b1;
    reset = 1'b0;
    #1 check("mid_reset_zero", 32'(observed()), 32'd0);
    step("mid_reset");
    reset = 1'b1;
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      #1 check("post_reset_idle", 32'(observed()), 32'd0);
      step("post_reset");
    end

    // Randomized run with occasional resets
    for (int n = 0; n < 3000; n++) begin
      random_inputs();
      reset = ($urandom_range(0, 199) != 0);
      step("random");
    end
    reset = 1'b1;
    clear_inputs();
    step("final_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
